traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Independent safety monitor that watches the six lamp drives (Ra, Ya, Ga, Rb, Yb, Gb) leaving the two-approach traffic light controller. It checks them every cycle for conflicting greens, malformed lamp codes, illegal colour sequences and short green/yellow intervals. On any violation it latches a fault with a cause code and drives a flashing-red command for the lamp output stage, overriding the controller.

## Interface
Parameters:
- MIN_GREEN, 5: minimum green duration per approach, in clock cycles.
- MIN_YELLOW, 1: minimum yellow duration per approach, in clock cycles.
- FLASH_DIV, 4: half-period of flash_red, in clock cycles. Must be ≥1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- Ra, Ya, Ga, input, 1 each: approach A lamp drives, as produced by the controller.
- Rb, Yb, Gb, input, 1 each: approach B lamp drives.
- clear_fault, input, 1: synchronous request to clear a latched fault.
- fault, output, 1: latched fault flag.
- fault_code, output, 3: cause of the latched fault. 0 = none, 1 = invalid lamp code, 2 = conflict, 3 = illegal sequence, 4 = short green, 5 = short yellow.
- flash_en, output, 1: equal to fault; lamp stage ignores controller and shows flash_red on both reds.
- flash_red, output, 1: flashing red drive while flash_en=1; otherwise 0.

## Operation
- Per-approach lamp state, decoded from live inputs:
  - R, Y or G when exactly one lamp is lit.
  - INVALID when zero or more than one lamp is lit.
- Registered history per approach:
  - prev: last decoded state, or UNK after reset/clear.
  - dur: 8-bit saturating count.
  - armed: 1 bit.
- Checks, evaluated every cycle on live inputs vs history:
  - Conflict (2): neither approach is R while both are valid (G/Y on A and G/Y on B).
  - Invalid (1): either approach decodes INVALID.
  - Sequence (3): per approach, live ≠ prev with prev ≠ UNK. Only G→Y, Y→R and R→G are legal.
  - Short green (4): G→Y transition with armed=1 and dur < MIN_GREEN.
  - Short yellow (5): Y→R transition with armed=1 and dur < MIN_YELLOW.
- Priority when several checks fire in the same cycle: 2 > 1 > 3 > 4 > 5. Across both approaches, the highest-priority cause is the one recorded.
- History update each edge:
  - live == prev: dur increments, saturating at 255.
  - live ≠ prev: dur := 1 and prev := live.
  - armed := 1 on the first transition observed after reset/clear. The interval in progress at reset/clear is therefore exempt from duration checks.
- Fault latch:
  - First violation sets fault=1 and fault_code.
  - Later violations do not change fault_code; the first cause is retained.
  - Remains set until reset_n or a clear takes effect.
- clear_fault:
  - Sampled at an edge. Takes effect only if no check fires in that cycle; otherwise it is ignored.
  - On success: fault=0, fault_code=0, prev := live decode, dur := 1, armed := 0, flash counter reset.
- Flash:
  - While fault=1, a counter divides clk; flash_red toggles every FLASH_DIV cycles.
  - flash_red starts at 1 on the edge where fault rises.
- History is tracked while a fault is latched.

## Timing
- Reset values: fault=0, fault_code=0, flash_en=0, flash_red=0, prev=UNK, dur=0, armed=0.
- Latency: a violation present on the inputs before edge k gives fault/fault_code valid after edge k (one cycle). flash_en follows fault in the same cycle.
- Duration counting: a lamp held for N sampled edges reports dur=N at the transition edge. Example: a controller green spanning 6 states passes MIN_GREEN=5; yellow of 1 state passes MIN_YELLOW=1.
- Reset mid-fault clears everything asynchronously. The first edge after release has prev=UNK, so no sequence check is made on that edge.
- clear_fault and a new violation in the same cycle: the violation wins; fault stays set and the old code is retained.
- dur saturation at 255 never flags a fault. Red duration is not checked.

## Configuration
- CONFLICT_MON_TIMING_EN:
  - Defined: dur counters, armed flags, and checks 4 and 5 are present.
  - Undefined: counters and armed flags are removed, and codes 4 and 5 are never produced. All other behaviour is identical.

## Test plan
- Legal cycle (A: G×6, Y×1, R×6; B: R×7, G×5, Y×1), repeated 3 times → fault=0 throughout.
- Ga=1 and Gb=1 driven before edge k → fault=1, fault_code=2 after edge k. flash_red reads 1,1,1,1,0,0,0,0,… for FLASH_DIV=4.
- Ra=Ga=1 on approach A with B red → fault_code=1. Then Gb=1 on the next cycle → code stays 1.
- A goes G→R directly after 6 green cycles → fault_code=3.
- After an armed cycle, A green held 3 cycles then Y → fault_code=4 with the macro defined; fault=0 with it undefined.
- fault latched with lamps now legal, pulse clear_fault → fault=0 and code=0 after the edge. Repeat while Ga=Gb=1 → fault stays 1.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Independent safety monitor for the six lamp drives of a two-approach
// traffic light controller. It latches the first conflict, malformed lamp
// code, illegal colour step or short interval it sees, and commands the
// lamp stage into flashing red until a clean clear or a reset.
// Optional build macro CONFLICT_MON_TIMING_EN adds the per-approach
// duration counters, armed flags and the short green / short yellow checks.

module traffic_conflict_monitor #(
  parameter int MIN_GREEN  = 5,
  parameter int MIN_YELLOW = 1,
  parameter int FLASH_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ra,
  input  logic       Ya,
  input  logic       Ga,
  input  logic       Rb,
  input  logic       Yb,
  input  logic       Gb,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic       flash_red
);

  typedef enum logic [2:0] {
    LAMP_UNK,
    LAMP_R,
    LAMP_Y,
    LAMP_G,
    LAMP_INV
  } lamp_e;

  localparam int              CW      = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(FLASH_DIV - 1);

  function automatic lamp_e decodeLamp(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  decodeLamp = LAMP_R;
      3'b010:  decodeLamp = LAMP_Y;
      3'b001:  decodeLamp = LAMP_G;
      default: decodeLamp = LAMP_INV;
    endcase
  endfunction

  function automatic logic legalStep(input lamp_e from, input lamp_e to);
    legalStep = (from == LAMP_G && to == LAMP_Y) ||
                (from == LAMP_Y && to == LAMP_R) ||
                (from == LAMP_R && to == LAMP_G);
  endfunction

  lamp_e          live [2];
  lamp_e          prev_q [2];
  lamp_e          prev_d [2];
`ifdef CONFLICT_MON_TIMING_EN
  logic [7:0]     dur_q [2];
  logic [7:0]     dur_d [2];
  logic [1:0]     armed_q;
  logic [1:0]     armed_d;
`endif
  logic [1:0]     trans;
  logic           conflictHit;
  logic           invalidHit;
  logic           seqHit;
  logic           shortGreenHit;
  logic           shortYellowHit;
  logic [2:0]     hitCode;
  logic           anyHit;
  logic           clearOk;

  logic           fault_q, fault_d;
  logic [2:0]     faultCode_q, faultCode_d;
  logic [CW-1:0]  flashCnt_q, flashCnt_d;
  logic           flashRed_q, flashRed_d;

  // Decode live lamps and evaluate every check against the registered history
  always_comb begin
    live[0]        = decodeLamp(Ra, Ya, Ga);
    live[1]        = decodeLamp(Rb, Yb, Gb);
    trans          = '0;
    seqHit         = 1'b0;
    shortGreenHit  = 1'b0;
    shortYellowHit = 1'b0;
    conflictHit    = (live[0] == LAMP_G || live[0] == LAMP_Y) &&
                     (live[1] == LAMP_G || live[1] == LAMP_Y);
    invalidHit     = (live[0] == LAMP_INV) || (live[1] == LAMP_INV);
    for (int i = 0; i < 2; i++) begin
      trans[i] = (live[i] != prev_q[i]) && (prev_q[i] != LAMP_UNK);
      if (trans[i] && !legalStep(prev_q[i], live[i])) seqHit = 1'b1;
`ifdef CONFLICT_MON_TIMING_EN
      if (trans[i] && armed_q[i] && prev_q[i] == LAMP_G && live[i] == LAMP_Y &&
          int'(dur_q[i]) < MIN_GREEN) shortGreenHit = 1'b1;
      if (trans[i] && armed_q[i] && prev_q[i] == LAMP_Y && live[i] == LAMP_R &&
          int'(dur_q[i]) < MIN_YELLOW) shortYellowHit = 1'b1;
`endif
    end
    if (conflictHit)         hitCode = 3'd2;
    else if (invalidHit)     hitCode = 3'd1;
    else if (seqHit)         hitCode = 3'd3;
    else if (shortGreenHit)  hitCode = 3'd4;
    else if (shortYellowHit) hitCode = 3'd5;
    else                     hitCode = 3'd0;
    anyHit  = (hitCode != 3'd0);
    clearOk = clear_fault && !anyHit;
  end

  // Next-state of the per-approach history; a clean clear restarts it from the live lamps
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      prev_d[i] = prev_q[i];
`ifdef CONFLICT_MON_TIMING_EN
      dur_d[i]   = dur_q[i];
      armed_d[i] = armed_q[i];
`endif
      if (clearOk) begin
        prev_d[i] = live[i];
`ifdef CONFLICT_MON_TIMING_EN
        dur_d[i]   = 8'd1;
        armed_d[i] = 1'b0;
`endif
      end else if (live[i] != prev_q[i]) begin
        prev_d[i] = live[i];
`ifdef CONFLICT_MON_TIMING_EN
        dur_d[i]   = 8'd1;
        armed_d[i] = armed_q[i] | trans[i];
`endif
      end else begin
`ifdef CONFLICT_MON_TIMING_EN
        dur_d[i] = (dur_q[i] == 8'hFF) ? dur_q[i] : dur_q[i] + 8'd1;
`endif
      end
    end
  end

  // Next-state of the fault latch and the flash divider; first cause is kept
  always_comb begin
    fault_d     = fault_q;
    faultCode_d = faultCode_q;
    flashCnt_d  = flashCnt_q;
    flashRed_d  = flashRed_q;
    if (!fault_q && anyHit) begin
      fault_d     = 1'b1;
      faultCode_d = hitCode;
      flashCnt_d  = '0;
      flashRed_d  = 1'b1;
    end else if (clearOk) begin
      fault_d     = 1'b0;
      faultCode_d = 3'd0;
      flashCnt_d  = '0;
      flashRed_d  = 1'b0;
    end else if (fault_q) begin
      if (flashCnt_q == CNT_MAX) begin
        flashCnt_d = '0;
        flashRed_d = ~flashRed_q;
      end else begin
        flashCnt_d = flashCnt_q + 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously to the power-up history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_q[i] <= LAMP_UNK;
`ifdef CONFLICT_MON_TIMING_EN
        dur_q[i]   <= 8'd0;
        armed_q[i] <= 1'b0;
`endif
      end
      fault_q     <= 1'b0;
      faultCode_q <= 3'd0;
      flashCnt_q  <= '0;
      flashRed_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        prev_q[i] <= prev_d[i];
`ifdef CONFLICT_MON_TIMING_EN
        dur_q[i]   <= dur_d[i];
        armed_q[i] <= armed_d[i];
`endif
      end
      fault_q     <= fault_d;
      faultCode_q <= faultCode_d;
      flashCnt_q  <= flashCnt_d;
      flashRed_q  <= flashRed_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = faultCode_q;
  assign flash_en   = fault_q;
  assign flash_red  = flashRed_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor
// Directed-vector bench for traffic_conflict_monitor. Lamp vectors are
// packed as {Ra,Ya,Ga,Rb,Yb,Gb}. Expectations for the short-green case
// follow the CONFLICT_MON_TIMING_EN build macro.

module tb_traffic_conflict_monitor;

  localparam int FLASH_DIV = 4;

  localparam logic [5:0] AG_BR   = 6'b001_100;
  localparam logic [5:0] AY_BR   = 6'b010_100;
  localparam logic [5:0] AR_BR   = 6'b100_100;
  localparam logic [5:0] AR_BG   = 6'b100_001;
  localparam logic [5:0] AR_BY   = 6'b100_010;
  localparam logic [5:0] AG_BG   = 6'b001_001;
  localparam logic [5:0] AINV_BR = 6'b101_100;
  localparam logic [5:0] AINV_BG = 6'b101_001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Ra, Ya, Ga, Rb, Yb, Gb;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_en;
  logic       flash_red;

  int assertCount = 0;
  int failCount   = 0;

  logic [5:0] legalSeq [13];
  logic       expShortFault;
  logic [2:0] expShortCode;
  logic [2:0] expFinalCode;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_GREEN (5),
    .MIN_YELLOW(1),
    .FLASH_DIV (FLASH_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Ra         (Ra),
    .Ya         (Ya),
    .Ga         (Ga),
    .Rb         (Rb),
    .Yb         (Yb),
    .Gb         (Gb),
    .clear_fault(clear_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_en   (flash_en),
    .flash_red  (flash_red)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkFault(input string tag, input logic expFault, input logic [2:0] expCode);
    checkOutput({tag, "_fault"}, {7'd0, fault}, {7'd0, expFault});
    checkOutput({tag, "_code"}, {5'd0, fault_code}, {5'd0, expCode});
    checkOutput({tag, "_flash_en"}, {7'd0, flash_en}, {7'd0, expFault});
  endtask

  task automatic applyStimulus(input logic [5:0] lamps, input logic clr);
    {Ra, Ya, Ga, Rb, Yb, Gb} = lamps;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    legalSeq[0]  = AG_BR; legalSeq[1]  = AG_BR; legalSeq[2]  = AG_BR;
    legalSeq[3]  = AG_BR; legalSeq[4]  = AG_BR; legalSeq[5]  = AG_BR;
    legalSeq[6]  = AY_BR;
    legalSeq[7]  = AR_BG; legalSeq[8]  = AR_BG; legalSeq[9]  = AR_BG;
    legalSeq[10] = AR_BG; legalSeq[11] = AR_BG;
    legalSeq[12] = AR_BY;
`ifdef CONFLICT_MON_TIMING_EN
    expShortFault = 1'b1;
    expShortCode  = 3'd4;
    expFinalCode  = 3'd4;
`else
    expShortFault = 1'b0;
    expShortCode  = 3'd0;
    expFinalCode  = 3'd2;
`endif

    reset_n     = 1'b0;
    clear_fault = 1'b0;
    {Ra, Ya, Ga, Rb, Yb, Gb} = AG_BR;
    #2;
    checkFault("reset", 1'b0, 3'd0);
    checkOutput("reset_flash_red", {7'd0, flash_red}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 13; s++) begin
        applyStimulus(legalSeq[s], 1'b0);
        checkOutput("legal_fault", {7'd0, fault}, 8'd0);
      end
    end

    applyStimulus(AG_BG, 1'b0);
    checkFault("conflict", 1'b1, 3'd2);
    for (int i = 0; i < 9; i++) begin
      checkOutput("flash_red", {7'd0, flash_red}, {7'd0, ((i / FLASH_DIV) % 2) == 0});
      if (i < 8) applyStimulus(AG_BG, 1'b0);
    end
    checkFault("conflict_hold", 1'b1, 3'd2);

    applyStimulus(AG_BR, 1'b0);
    checkFault("conflict_seq_after", 1'b1, 3'd2);
    applyStimulus(AG_BR, 1'b1);
    checkFault("clear_ok", 1'b0, 3'd0);
    checkOutput("clear_flash_red", {7'd0, flash_red}, 8'd0);

    applyStimulus(AINV_BR, 1'b0);
    checkFault("invalid", 1'b1, 3'd1);
    applyStimulus(AINV_BG, 1'b0);
    checkFault("invalid_keep", 1'b1, 3'd1);

    #2;
    reset_n = 1'b0;
    #1;
    checkFault("async_reset", 1'b0, 3'd0);
    checkOutput("async_reset_flash_red", {7'd0, flash_red}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(AG_BR, 1'b0);
      checkOutput("post_reset_green", {7'd0, fault}, 8'd0);
    end
    applyStimulus(AR_BR, 1'b0);
    checkFault("sequence", 1'b1, 3'd3);
    applyStimulus(AR_BR, 1'b1);
    checkFault("seq_clear", 1'b0, 3'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(AG_BR, 1'b0);
      checkOutput("short_green_hold", {7'd0, fault}, 8'd0);
    end
    applyStimulus(AY_BR, 1'b0);
    checkFault("short_green", expShortFault, expShortCode);

    applyStimulus(AG_BG, 1'b1);
    checkFault("clear_vs_conflict", 1'b1, expFinalCode);
    applyStimulus(AG_BG, 1'b1);
    checkFault("clear_vs_conflict_again", 1'b1, expFinalCode);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
